// File: rtl/ddr4_sched_pkg.sv
// ddr4_sched_pkg: shared encodings for the DDR4 ping-pong burst scheduler.
package ddr4_sched_pkg;

    localparam int BANK_W = 2;

    typedef enum logic [BANK_W-1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARB      = 2'd1,
        S_WR_BURST = 2'd2,
        S_RD_BURST = 2'd3
    } sched_state_e;

    function automatic logic bank_writable(bank_state_e s);
        return (s == BANK_FREE) || (s == BANK_FILLING);
    endfunction

    function automatic logic bank_readable(bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// ddr4_bank_tracker: lifecycle of one ping-pong page bank (FREE->FILLING->FULL->DRAINING->FREE).
module ddr4_bank_tracker
    import ddr4_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_wr,
    input  logic        start_rd,
    input  logic        last_wr_done,
    input  logic        last_rd_done,
    output bank_state_e state
);

    bank_state_e state_q, state_d;

    // Requests that do not match the current state are dropped, so a bank can
    // never be read while filling nor rewritten before it has been drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BANK_FREE:     state_d = start_wr     ? BANK_FILLING  : state_q;
            BANK_FILLING:  state_d = last_wr_done ? BANK_FULL     : state_q;
            BANK_FULL:     state_d = start_rd     ? BANK_DRAINING : state_q;
            BANK_DRAINING: state_d = last_rd_done ? BANK_FREE     : state_q;
            default:       state_d = BANK_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BANK_FREE;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/ddr4_pingpong_sched.sv
// ddr4_pingpong_sched: arbitrates one MIG burst at a time between write and read sides over two page banks.
// Optional burst/stall statistics outputs are enabled with `define DDR4_SCHED_STATS_EN.
module ddr4_pingpong_sched
    import ddr4_sched_pkg::*;
#(
    parameter int FIFO_DEPTH      = 512,
    parameter int CNT_W           = 9,
    parameter int BURST_LEN       = 8,
    parameter int BURSTS_PER_PAGE = 8,
    parameter int STARVE_MAX      = 4,
    localparam int IDX_W          = $clog2(BURSTS_PER_PAGE)
) (
    input  logic             ui_clk,
    input  logic             rst_n,
    input  logic             init_calib_complete,
    input  logic [CNT_W-1:0] wfifo_rcount,
    input  logic [CNT_W-1:0] rfifo_wcount,
    input  logic             rd_allow,
    input  logic             burst_done,
    output logic             cmd_valid,
    output logic             cmd_is_rd,
    output logic             cmd_bank,
    output logic [IDX_W-1:0] cmd_burst_idx,
    output logic             read_start,
    output logic             page_wr_done,
    output logic             page_rd_done,
    output logic             wr_stall,
    output logic [3:0]       bank_state
`ifdef DDR4_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_wr_bursts,
    output logic [31:0]      stat_rd_bursts,
    output logic [31:0]      stat_stall_cycles
`endif
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    sched_state_e     state_q, state_d;
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             cmd_valid_q, cmd_valid_d, cmd_is_rd_q, cmd_is_rd_d;
    logic             cmd_bank_q, cmd_bank_d;
    logic [IDX_W-1:0] cmd_idx_q, cmd_idx_d;
    logic             page_wr_done_q, page_wr_done_d, page_rd_done_q, page_rd_done_d;
    logic             read_start_q, read_start_d;

    bank_state_e bank_st [2];
    logic        wr_data, rd_space, wr_ok, rd_ok, go_wr, go_rd;
    logic        last_wr, last_rd;

    assign wr_data  = {1'b0, wfifo_rcount} >= (CNT_W+1)'(BURST_LEN);
    assign rd_space = {1'b0, rfifo_wcount} <= (CNT_W+1)'(FIFO_DEPTH - BURST_LEN);
    assign wr_ok    = wr_data && bank_writable(bank_st[wr_bank_q]);
    assign rd_ok    = rd_space && rd_allow && bank_readable(bank_st[rd_bank_q]);
    assign go_rd    = (state_q == S_ARB) && rd_ok && (!wr_ok || starve_q == SC_W'(STARVE_MAX));
    assign go_wr    = (state_q == S_ARB) && !go_rd && wr_ok;
    assign last_wr  = (state_q == S_WR_BURST) && burst_done && wr_idx_q == IDX_W'(BURSTS_PER_PAGE - 1);
    assign last_rd  = (state_q == S_RD_BURST) && burst_done && rd_idx_q == IDX_W'(BURSTS_PER_PAGE - 1);
    assign wr_stall = (state_q == S_ARB) && wr_data && bank_readable(bank_st[wr_bank_q]);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        ddr4_bank_tracker u_bank (
            .clk          (ui_clk),
            .rst_n        (rst_n),
            .start_wr     (go_wr && wr_bank_q == g[0]),
            .start_rd     (go_rd && rd_bank_q == g[0]),
            .last_wr_done (last_wr && cmd_bank_q == g[0]),
            .last_rd_done (last_rd && cmd_bank_q == g[0]),
            .state        (bank_st[g])
        );
    end

    always_comb begin
        state_d        = state_q;
        wr_bank_d      = wr_bank_q;
        rd_bank_d      = rd_bank_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        starve_d       = starve_q;
        cmd_is_rd_d    = cmd_is_rd_q;
        cmd_bank_d     = cmd_bank_q;
        cmd_idx_d      = cmd_idx_q;
        page_wr_done_d = 1'b0;
        page_rd_done_d = 1'b0;
        read_start_d   = read_start_q;
        case (state_q)
            S_IDLE: state_d = init_calib_complete ? S_ARB : S_IDLE;
            S_ARB: begin
                if (go_rd) begin
                    state_d     = S_RD_BURST;
                    starve_d    = '0;
                    cmd_is_rd_d = 1'b1;
                    cmd_bank_d  = rd_bank_q;
                    cmd_idx_d   = rd_idx_q;
                end else if (go_wr) begin
                    state_d     = S_WR_BURST;
                    starve_d    = (rd_ok && starve_q != SC_W'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
                    cmd_is_rd_d = 1'b0;
                    cmd_bank_d  = wr_bank_q;
                    cmd_idx_d   = wr_idx_q;
                end
            end
            S_WR_BURST: begin
                if (burst_done) begin
                    state_d        = S_ARB;
                    wr_idx_d       = last_wr ? '0 : wr_idx_q + 1'b1;
                    wr_bank_d      = wr_bank_q ^ last_wr;
                    page_wr_done_d = last_wr;
                    read_start_d   = read_start_q | last_wr;
                end
            end
            S_RD_BURST: begin
                if (burst_done) begin
                    state_d        = S_ARB;
                    rd_idx_d       = last_rd ? '0 : rd_idx_q + 1'b1;
                    rd_bank_d      = rd_bank_q ^ last_rd;
                    page_rd_done_d = last_rd;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_valid_d = (state_d == S_WR_BURST) || (state_d == S_RD_BURST);
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            starve_q       <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_is_rd_q    <= 1'b0;
            cmd_bank_q     <= 1'b0;
            cmd_idx_q      <= '0;
            page_wr_done_q <= 1'b0;
            page_rd_done_q <= 1'b0;
            read_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            starve_q       <= starve_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_is_rd_q    <= cmd_is_rd_d;
            cmd_bank_q     <= cmd_bank_d;
            cmd_idx_q      <= cmd_idx_d;
            page_wr_done_q <= page_wr_done_d;
            page_rd_done_q <= page_rd_done_d;
            read_start_q   <= read_start_d;
        end
    end

    assign cmd_valid     = cmd_valid_q;
    assign cmd_is_rd     = cmd_is_rd_q;
    assign cmd_bank      = cmd_bank_q;
    assign cmd_burst_idx = cmd_idx_q;
    assign read_start    = read_start_q;
    assign page_wr_done  = page_wr_done_q;
    assign page_rd_done  = page_rd_done_q;
    assign bank_state    = {bank_st[1], bank_st[0]};

`ifdef DDR4_SCHED_STATS_EN
    logic [31:0] stat_wr_q, stat_rd_q, stat_stall_q;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q    <= '0;
            stat_rd_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (state_q == S_WR_BURST && burst_done && !(&stat_wr_q)) stat_wr_q <= stat_wr_q + 1'b1;
            if (state_q == S_RD_BURST && burst_done && !(&stat_rd_q)) stat_rd_q <= stat_rd_q + 1'b1;
            if (wr_stall && !(&stat_stall_q)) stat_stall_q <= stat_stall_q + 1'b1;
        end
    end

    assign stat_wr_bursts    = stat_wr_q;
    assign stat_rd_bursts    = stat_rd_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_ddr4_pingpong_sched.sv
// tb_ddr4_pingpong_sched: scoreboard bench; expected burst commands are queued per scenario and checked as the DUT issues them.
module tb_ddr4_pingpong_sched;

    logic       ui_clk = 0, rst_n = 0, init_calib_complete = 0, rd_allow = 0, burst_done = 0;
    logic [8:0] wfifo_rcount = 0, rfifo_wcount = 0;
    logic       cmd_valid, cmd_is_rd, cmd_bank, read_start, page_wr_done, page_rd_done, wr_stall;
    logic [2:0] cmd_burst_idx;
    logic [3:0] bank_state;

    typedef struct packed { logic rd; logic bank; logic [2:0] idx; } cmd_t;
    cmd_t exp_q[$];
    int   n_checks = 0, n_fail = 0, pwd_cnt = 0, prd_cnt = 0;

    ddr4_pingpong_sched dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .wfifo_rcount(wfifo_rcount), .rfifo_wcount(rfifo_wcount), .rd_allow(rd_allow),
        .burst_done(burst_done), .cmd_valid(cmd_valid), .cmd_is_rd(cmd_is_rd),
        .cmd_bank(cmd_bank), .cmd_burst_idx(cmd_burst_idx), .read_start(read_start),
        .page_wr_done(page_wr_done), .page_rd_done(page_rd_done), .wr_stall(wr_stall),
        .bank_state(bank_state)
    );

    always #5 ui_clk = ~ui_clk;

    always @(negedge ui_clk) begin
        if (page_wr_done) pwd_cnt++;
        if (page_rd_done) prd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ui_clk);
        #1;
    endtask

    task automatic push(input logic rd, input logic bank, input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({rd, bank, 3'(i)});
    endtask

    // Engine model: waits for a command, optionally completes it with a burst_done pulse.
    task automatic engine_step(input bit do_done, output cmd_t got, output bit to);
        int k = 0;
        to = 0;
        got = '0;
        while (cmd_valid !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        if (cmd_valid !== 1'b1) begin
            to = 1;
            return;
        end
        got = {cmd_is_rd, cmd_bank, cmd_burst_idx};
        if (!do_done) return;
        tick(2);
        burst_done = 1;
        tick(1);
        burst_done = 0;
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        rst_n = 0;
        wfifo_rcount = 9'd64;
        tick(2);
        outs = {cmd_valid, cmd_is_rd, cmd_bank, cmd_burst_idx, read_start, page_wr_done, page_rd_done, wr_stall, bank_state};
        n_checks++;
        if (outs !== 14'd0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", outs); end
        rst_n = 1;
        tick(5);
        n_checks++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL no_calib_cmd: got %b exp 0", cmd_valid); end
        init_calib_complete = 1;
        tick(1);
        n_checks++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL calib_plus1: got %b exp 0", cmd_valid); end
        tick(1);
        n_checks++;
        if ({cmd_valid, cmd_is_rd, cmd_bank, cmd_burst_idx} !== 6'b100000) begin
            n_fail++;
            $display("FAIL calib_plus2: got v=%b rd=%b bank=%b idx=%0d exp v=1 rd=0 bank=0 idx=0", cmd_valid, cmd_is_rd, cmd_bank, cmd_burst_idx);
        end
    endtask

    task automatic test_page_fill();
        cmd_t got, e;
        bit to;
        int p0 = pwd_cnt;
        push(0, 0, 0, 7);
        while (exp_q.size() > 0) begin
            engine_step(1, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin n_fail++; $display("FAIL page_fill_cmd: got %h (timeout=%0d) exp %h", got, to, e); end
        end
        n_checks++;
        if (bank_state !== 4'b0010) begin n_fail++; $display("FAIL page_fill_banks: got %b exp 0010", bank_state); end
        tick(1);
        n_checks++;
        if (pwd_cnt - p0 !== 1) begin n_fail++; $display("FAIL page_wr_done_count: got %0d exp 1", pwd_cnt - p0); end
        n_checks++;
        if (read_start !== 1'b1) begin n_fail++; $display("FAIL read_start: got %b exp 1", read_start); end
        push(0, 1, 0, 0);
        engine_step(1, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin n_fail++; $display("FAIL next_bank_cmd: got %h (timeout=%0d) exp %h", got, to, e); end
    endtask

    task automatic test_pingpong_block();
        cmd_t got, e;
        bit to, seen;
        push(0, 1, 1, 7);
        while (exp_q.size() > 0) begin
            engine_step(1, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin n_fail++; $display("FAIL pingpong_cmd: got %h (timeout=%0d) exp %h", got, to, e); end
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cmd_valid) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL pingpong_no_cmd: got cmd_valid=1 exp 0"); end
        n_checks++;
        if (wr_stall !== 1'b1) begin n_fail++; $display("FAIL pingpong_stall: got %b exp 1", wr_stall); end
        n_checks++;
        if (bank_state !== 4'b1010) begin n_fail++; $display("FAIL pingpong_banks: got %b exp 1010", bank_state); end
        n_checks++;
        if (pwd_cnt !== 2) begin n_fail++; $display("FAIL pingpong_pages: got %0d exp 2", pwd_cnt); end
    endtask

    task automatic test_fifo_limit();
        cmd_t got, e;
        bit to, seen;
        int p0 = prd_cnt;
        rd_allow = 1;
        rfifo_wcount = 9'd505;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cmd_valid) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rfifo_505_no_read: got cmd_valid=1 exp 0"); end
        rfifo_wcount = 9'd504;
        push(1, 0, 0, 7);
        while (exp_q.size() > 0) begin
            engine_step(1, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin n_fail++; $display("FAIL rfifo_504_read: got %h (timeout=%0d) exp %h", got, to, e); end
        end
        n_checks++;
        if (bank_state !== 4'b1000) begin n_fail++; $display("FAIL drain_banks: got %b exp 1000", bank_state); end
        tick(1);
        n_checks++;
        if (prd_cnt - p0 !== 1) begin n_fail++; $display("FAIL page_rd_done_count: got %0d exp 1", prd_cnt - p0); end
    endtask

    task automatic test_starvation();
        cmd_t got, e;
        bit to;
        push(0, 0, 0, 3);
        push(1, 1, 0, 0);
        push(0, 0, 4, 7);
        push(1, 1, 1, 7);
        push(0, 1, 0, 3);
        push(1, 0, 0, 0);
        while (exp_q.size() > 0) begin
            engine_step(1, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin n_fail++; $display("FAIL starve_seq: got %h (timeout=%0d) exp %h", got, to, e); end
        end
    endtask

    task automatic test_async_reset();
        cmd_t got, e;
        bit to;
        logic [13:0] outs;
        int pw, pr;
        push(0, 1, 4, 7);
        while (exp_q.size() > 0) begin
            engine_step(1, got, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e) begin n_fail++; $display("FAIL pre_reset_cmd: got %h (timeout=%0d) exp %h", got, to, e); end
        end
        push(1, 0, 1, 1);
        engine_step(0, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin n_fail++; $display("FAIL mid_read_cmd: got %h (timeout=%0d) exp %h", got, to, e); end
        #3;
        rst_n = 0;
        init_calib_complete = 0;
        #1;
        outs = {cmd_valid, cmd_is_rd, cmd_bank, cmd_burst_idx, read_start, page_wr_done, page_rd_done, wr_stall, bank_state};
        n_checks++;
        if (outs !== 14'd0) begin n_fail++; $display("FAIL async_reset_outputs: got %h exp 0", outs); end
        tick(2);
        pw = pwd_cnt;
        pr = prd_cnt;
        rst_n = 1;
        tick(1);
        burst_done = 1;
        tick(1);
        burst_done = 0;
        tick(2);
        outs = {cmd_valid, cmd_is_rd, cmd_bank, cmd_burst_idx, read_start, page_wr_done, page_rd_done, wr_stall, bank_state};
        n_checks++;
        if (outs !== 14'd0 || pwd_cnt !== pw || prd_cnt !== pr) begin
            n_fail++;
            $display("FAIL stray_done: got outs=%h pages=%0d/%0d exp 0 pages=%0d/%0d", outs, pwd_cnt, prd_cnt, pw, pr);
        end
        init_calib_complete = 1;
        push(0, 0, 0, 0);
        engine_step(1, got, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e) begin n_fail++; $display("FAIL post_reset_cmd: got %h (timeout=%0d) exp %h", got, to, e); end
    endtask

    initial begin
        test_reset();
        test_page_fill();
        test_pingpong_block();
        test_fifo_limit();
        test_starvation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
